// File: rtl/pipe_pkg.sv
// Shared constants for the skid-buffered pipeline stage.
// State encoding is the pair {main_v, skid_v}; (0,1) is never produced.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;
    localparam logic [1:0] ST_BAD   = 2'b01;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int CTRL_W_DEF = 8;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Ready/valid link carrying an opaque payload plus a control vector.
//   valid : producer has a transfer
//   ready : consumer accepts
//   data  : payload
//   ctrl  : control vector
// master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = pipe_pkg::CTRL_W_DEF
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_entry.sv
// One storage entry of the pipeline stage: payload + control + valid bit.
//   clk, rst     : clock, async active-low reset
//   clr          : drop the entry and force ctrl to the bubble value
//   load         : capture d_data/d_ctrl and mark valid
//   drop         : mark invalid, keep stored contents
//   d_data/d_ctrl: values captured on load
//   q_valid/q_data/q_ctrl : stored entry
// Priority: clr > load > drop.
module pipe_entry #(
    parameter int                DATA_W      = 16,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ctrl  <= CTRL_BUBBLE;
        end else if (clr) begin
            // data is left stale on purpose; only ctrl must read as a bubble
            q_valid <= 1'b0;
            q_ctrl  <= CTRL_BUBBLE;
        end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end else if (drop) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with a 2-entry skid buffer.
//   clk, rst   : clock, async active-low reset
//   flush      : synchronous squash of all held entries
//   up         : upstream link (slave); up.ready is a flop output
//   dn         : downstream link (master); dn.ctrl is the bubble when idle
//   occ        : number of held entries (0..2)
//   stall_cnt  : saturating count of cycles with dn.valid & ~dn.ready
//   stall_clr  : synchronous clear of stall_cnt, wins over increment
//
// state | meaning
// EMPTY | nothing held, ready to accept
// ONE   | main holds the head, skid empty
// FULL  | main holds the head, skid holds the next entry, ready low
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 stall_clr,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic [1:0]           occ,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic              in_ready, in_fire, out_fire;
    logic [1:0]        st, st_nxt;
    logic              clr_all, main_ld, main_drop, skid_ld, skid_drop;

    // The state register is the pair of valid bits inside the two entries.
    assign st       = {main_v, skid_v};
    assign in_ready = ~skid_v;
    assign in_fire  = up.valid & in_ready & ~flush;
    assign out_fire = main_v & dn.ready;

    always_comb begin
        st_nxt = st;
        if (flush) begin
            st_nxt = ST_EMPTY;
        end else begin
            case (st)
                ST_EMPTY: if (in_fire) st_nxt = ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_fire)      st_nxt = ST_FULL;
                    else if (!in_fire && out_fire) st_nxt = ST_EMPTY;
                end
                ST_FULL:  if (out_fire) st_nxt = ST_ONE;
                default:  st_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        clr_all   = flush | (st == ST_BAD);
        main_ld   = ((st == ST_EMPTY) && (st_nxt == ST_ONE))
                  | ((st == ST_ONE)   && (st_nxt == ST_ONE) && in_fire)
                  | ((st == ST_FULL)  && (st_nxt == ST_ONE));
        main_drop = (st == ST_ONE)  && (st_nxt == ST_EMPTY);
        skid_ld   = (st == ST_ONE)  && (st_nxt == ST_FULL);
        skid_drop = (st == ST_FULL) && (st_nxt == ST_ONE);
        // Draining FULL promotes the skid entry; otherwise main takes upstream.
        main_d_data = (st == ST_FULL) ? skid_data : up.data;
        main_d_ctrl = (st == ST_FULL) ? skid_ctrl : up.ctrl;
    end

    pipe_entry #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_all),
        .load    (main_ld),
        .drop    (main_drop),
        .d_data  (main_d_data),
        .d_ctrl  (main_d_ctrl),
        .q_valid (main_v),
        .q_data  (main_data),
        .q_ctrl  (main_ctrl)
    );

    pipe_entry #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_all),
        .load    (skid_ld),
        .drop    (skid_drop),
        .d_data  (up.data),
        .d_ctrl  (up.ctrl),
        .q_valid (skid_v),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (main_v && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign up.ready = in_ready;
    assign dn.valid = main_v;
    assign dn.data  = main_data;
    assign dn.ctrl  = main_v ? main_ctrl : CTRL_BUBBLE;
    assign occ      = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure,
// flush in FULL and ONE, stall counter saturation/clear, mid-stream reset.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int         DATA_W = 16;
    localparam int         CTRL_W = 8;
    localparam int         CNT_W  = 4;
    localparam logic [7:0] BUB    = 8'h5A;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic stall_clr;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

    pipe_stage_skid #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (BUB),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall_clr (stall_clr),
        .up        (up_if),
        .dn        (dn_if),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic rdy);
        up_if.valid = v;
        up_if.data  = d;
        up_if.ctrl  = d[7:0] ^ 8'h80;
        dn_if.ready = rdy;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; stall_clr = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        #12;
        chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
        chk("rst_in_ready",  32'(up_if.ready), 32'd1);
        chk("rst_occ",       32'(occ),         32'(OCC_EMPTY));
        chk("rst_out_ctrl",  32'(dn_if.ctrl),  32'(BUB));
        chk("rst_stall",     32'(stall_cnt),   32'd0);
        step();
        rst = 1'b1;

        // Streaming 0x0001..0x0008 with out_ready high.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 1'b1);
            step();
            chk("stream_data",  32'(dn_if.data),  32'(i));
            chk("stream_ctrl",  32'(dn_if.ctrl),  32'(i ^ 8'h80));
            chk("stream_occ",   32'(occ),         32'(OCC_ONE));
            chk("stream_stall", 32'(stall_cnt),   32'd0);
        end
        drive(1'b0, 16'h0000, 1'b1);
        step();
        chk("stream_drain_occ",   32'(occ),         32'(OCC_EMPTY));
        chk("stream_drain_ctrl",  32'(dn_if.ctrl),  32'(BUB));

        // Back-pressure.
        drive(1'b1, 16'h00A1, 1'b1);
        step();
        chk("bp_a1_head", 32'(dn_if.data), 32'h00A1);
        drive(1'b1, 16'h00A2, 1'b0);
        step();
        chk("bp_full_occ",   32'(occ),         32'(OCC_FULL));
        chk("bp_full_ready", 32'(up_if.ready), 32'd0);
        chk("bp_full_head",  32'(dn_if.data),  32'h00A1);
        chk("bp_stall1",     32'(stall_cnt),   32'd1);
        drive(1'b1, 16'h00A3, 1'b0);
        step();
        chk("bp_stall2", 32'(stall_cnt), 32'd2);
        step();
        chk("bp_stall3",     32'(stall_cnt),   32'd3);
        chk("bp_hold_occ",   32'(occ),         32'(OCC_FULL));
        chk("bp_hold_data",  32'(dn_if.data),  32'h00A1);
        chk("bp_hold_ctrl",  32'(dn_if.ctrl),  32'h0021);
        chk("bp_hold_valid", 32'(dn_if.valid), 32'd1);
        dn_if.ready = 1'b1;
        step();
        chk("bp_rel_a2",     32'(dn_if.data),  32'h00A2);
        chk("bp_rel_occ",    32'(occ),         32'(OCC_ONE));
        chk("bp_rel_ready",  32'(up_if.ready), 32'd1);
        step();
        chk("bp_rel_a3",     32'(dn_if.data),  32'h00A3);
        chk("bp_rel_a3_ctl", 32'(dn_if.ctrl),  32'h0023);
        drive(1'b0, 16'h0000, 1'b1);
        step();
        chk("bp_end_occ",   32'(occ),       32'(OCC_EMPTY));
        chk("bp_end_stall", 32'(stall_cnt), 32'd3);

        // Flush in FULL while 0x00FF is offered.
        drive(1'b1, 16'h00B1, 1'b0);
        step();
        drive(1'b1, 16'h00B2, 1'b0);
        step();
        chk("fl_full_occ", 32'(occ), 32'(OCC_FULL));
        chk("fl_stall4",   32'(stall_cnt), 32'd4);
        drive(1'b1, 16'h00FF, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_occ",       32'(occ),         32'(OCC_EMPTY));
        chk("fl_valid",     32'(dn_if.valid), 32'd0);
        chk("fl_ctrl",      32'(dn_if.ctrl),  32'(BUB));
        chk("fl_ready",     32'(up_if.ready), 32'd1);
        chk("fl_stall5",    32'(stall_cnt),   32'd5);
        drive(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_ff_valid", 32'(dn_if.valid), 32'd0);
        end

        // Flush while ONE with out_ready high: head still transfers.
        drive(1'b1, 16'h00C1, 1'b1);
        step();
        drive(1'b1, 16'h00C2, 1'b1);
        flush = 1'b1;
        chk("fl1_head_valid", 32'(dn_if.valid), 32'd1);
        chk("fl1_head_data",  32'(dn_if.data),  32'h00C1);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 1'b1);
        chk("fl1_occ",   32'(occ),         32'(OCC_EMPTY));
        chk("fl1_valid", 32'(dn_if.valid), 32'd0);
        step();
        chk("fl1_no_c2", 32'(dn_if.valid), 32'd0);

        // Stall counter saturation and clear priority.
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("cnt_clr0", 32'(stall_cnt), 32'd0);
        drive(1'b1, 16'h00D1, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) step();
        chk("cnt_sat",      32'(stall_cnt),  32'd15);
        chk("cnt_sat_head", 32'(dn_if.data), 32'h00D1);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("cnt_clr_prio", 32'(stall_cnt), 32'd0);
        step();
        chk("cnt_restart",  32'(stall_cnt), 32'd1);

        // Mid-stream asynchronous reset with two entries held.
        drive(1'b1, 16'h00D2, 1'b0);
        step();
        chk("mr_occ_full", 32'(occ), 32'(OCC_FULL));
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(dn_if.valid), 32'd0);
        chk("mr_ready", 32'(up_if.ready), 32'd1);
        chk("mr_occ",   32'(occ),         32'(OCC_EMPTY));
        chk("mr_ctrl",  32'(dn_if.ctrl),  32'(BUB));
        chk("mr_stall", 32'(stall_cnt),   32'd0);
        step();
        rst = 1'b1;
        drive(1'b1, 16'h00E1, 1'b1);
        step();
        chk("mr_first_valid", 32'(dn_if.valid), 32'd1);
        chk("mr_first_data",  32'(dn_if.data),  32'h00E1);
        drive(1'b0, 16'h0000, 1'b1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
